aes_round_scheduler: RTL

Sequencer that shares one single-round AES datapath between two requesters. Each accepted block is iterated through Nr+1 round steps, encrypt or decrypt per request, and the result is returned on a single response channel tagged with the requester id. It replaces the fully unrolled combinational cipher with one round unit reused every cycle. The round unit and key schedule sit outside this block and are addressed through `rnd_idx`.

---
 rtl/aes_pkg.sv | 29 ++
 rtl/aes_rr_arb2.sv | 44 ++++
 rtl/aes_round_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round scheduler: FSM state encoding,
// round-index width and the legal (N, Nr, Nk) key-size triples.
package aes_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } sched_state_e;

    localparam int ROUND_IDX_W = 4;

    localparam int AES128_N = 128;
    localparam int AES128_NR = 10;
    localparam int AES128_NK = 4;
    localparam int AES192_N = 192;
    localparam int AES192_NR = 12;
    localparam int AES192_NK = 6;
    localparam int AES256_N = 256;
    localparam int AES256_NR = 14;
    localparam int AES256_NK = 8;

    function automatic bit aes_cfg_legal(input int n, input int nr, input int nk);
        return (n == AES128_N && nr == AES128_NR && nk == AES128_NK) ||
               (n == AES192_N && nr == AES192_NR && nk == AES192_NK) ||
               (n == AES256_N && nr == AES256_NR && nk == AES256_NK);
    endfunction

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-input round-robin arbiter. A tie goes to the requester not granted last;
// the last-grant pointer only moves on the accept strobe.
module aes_rr_arb2
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (accept_i) begin
            last_d = gnt_o[1];
        end
    end

    // Pointer resets to 1 so requester 0 wins the first tie.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/aes_round_scheduler.sv
// Shares one external single-round AES unit between two requesters, stepping each
// block through Nr+1 rounds. Define AES_SCHED_STATS_EN to add the blk_count output.
module aes_round_scheduler
    import aes_pkg::*;
#(
    parameter int N  = AES128_N,
    parameter int Nr = AES128_NR,
    parameter int Nk = AES128_NK
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [127:0]           req0_data,
    input  logic                   req0_decrypt,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [127:0]           req1_data,
    input  logic                   req1_decrypt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [127:0]           rsp_data,
    output logic [127:0]           rnd_state,
    output logic [ROUND_IDX_W-1:0] rnd_idx,
    output logic                   rnd_decrypt,
    output logic                   rnd_first,
    output logic                   rnd_last,
    input  logic [127:0]           rnd_result
`ifdef AES_SCHED_STATS_EN
    ,
    output logic [15:0]            blk_count
`endif
);

    localparam logic [ROUND_IDX_W-1:0] NR_IDX = ROUND_IDX_W'(Nr);

    if (!aes_cfg_legal(N, Nr, Nk)) begin : g_cfg_illegal
        $error("aes_round_scheduler: illegal (N, Nr, Nk) combination");
    end

    sched_state_e           fsm_q, fsm_d;
    logic [127:0]           state_q, state_d;
    logic [ROUND_IDX_W-1:0] step_q, step_d;
    logic                   dec_q, dec_d;
    logic                   id_q, id_d;
    logic [1:0]             gnt;
    logic                   in_idle;
    logic                   accept;

    aes_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({req1_valid, req0_valid}),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign in_idle    = (fsm_q == S_IDLE);
    assign req0_ready = in_idle & gnt[0];
    assign req1_ready = in_idle & gnt[1];
    assign accept     = in_idle & (gnt != 2'b00);

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        step_d  = step_q;
        dec_d   = dec_q;
        id_d    = id_q;
        case (fsm_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = gnt[1] ? req1_data : req0_data;
                    dec_d   = gnt[1] ? req1_decrypt : req0_decrypt;
                    id_d    = gnt[1];
                    step_d  = '0;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = rnd_result;
                step_d  = step_q + ROUND_IDX_W'(1);
                if (step_q == NR_IDX) begin
                    fsm_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            step_q  <= '0;
            dec_q   <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            step_q  <= step_d;
            dec_q   <= dec_d;
            id_q    <= id_d;
        end
    end

    // Decrypt walks the key schedule backwards; step never exceeds Nr in ROUND.
    always_comb begin
        rnd_state   = '0;
        rnd_idx     = '0;
        rnd_decrypt = 1'b0;
        rnd_first   = 1'b0;
        rnd_last    = 1'b0;
        if (fsm_q == S_ROUND) begin
            rnd_state   = state_q;
            rnd_idx     = dec_q ? (NR_IDX - step_q) : step_q;
            rnd_decrypt = dec_q;
            rnd_first   = (step_q == '0);
            rnd_last    = (step_q == NR_IDX);
        end
    end

    assign rsp_valid = (fsm_q == S_DONE);
    assign rsp_data  = rsp_valid ? state_q : '0;
    assign rsp_id    = rsp_valid & id_q;

`ifdef AES_SCHED_STATS_EN
    logic [15:0] blk_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_count_q <= '0;
        end else if (rsp_valid && rsp_ready) begin
            blk_count_q <= blk_count_q + 16'd1;
        end
    end

    assign blk_count = blk_count_q;
`endif

endmodule
